// File: rtl/conway_scan_reader.sv
// Raster-order reader of the Conway generation grid: fetches words on port B and emits one cell per pix_req.
// Pixel appears one cycle after pix_req; one read in flight at a time, address_b held while wait_request is high.
module conway_scan_reader #(
    parameter int WORD_W        = 20,
    parameter int WORDS_PER_ROW = 64,
    parameter int ROWS          = 1024,
    parameter int ADDR_W        = 16,
    parameter int RD_LATENCY    = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              frame_start,
    input  logic              line_start,
    input  logic              pix_req,
    output logic [ADDR_W-1:0] address_b,
    input  logic [WORD_W-1:0] q_b,
    input  logic              wait_request,
    output logic              ready_sig,
    output logic              pixel,
    output logic              pixel_valid,
    output logic              underflow
);
    localparam int PIX_PER_ROW = WORD_W * WORDS_PER_ROW;
    localparam int WPR_W       = $clog2(WORDS_PER_ROW);
    localparam int ROW_W       = ADDR_W - WPR_W;
    localparam int BIT_W       = $clog2(WORD_W);
    localparam int CNT_W       = $clog2(PIX_PER_ROW + 1);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
    state_t r_state, w_next_state;

    logic [WORD_W-1:0]     r_front, r_back;
    logic                  r_front_vld, r_back_vld;
    logic [ADDR_W:0]       r_fetch_ptr;
    logic [ADDR_W-1:0]     r_addr;
    logic                  r_req_pend;
    logic [RD_LATENCY-1:0] r_rd_pipe;
    logic [BIT_W-1:0]      r_bit;
    logic [CNT_W-1:0]      r_pix_cnt;
    logic [ROW_W-1:0]      r_row;
    logic                  r_first_line;
    logic                  r_ready, r_pixel, r_pixel_valid, r_underflow;

    logic                  w_scan, w_pix_ok, w_in_row, w_consume, w_shift, w_frame_end;
    logic                  w_ls, w_short, w_capture, w_accept, w_issue;
    logic [ROW_W:0]        w_next_row;
    logic [ADDR_W:0]       w_row_ptr;
    logic [RD_LATENCY:0]   w_pipe_nxt;

    always_comb begin
        w_scan      = (r_state == SCAN) && !frame_start;
        w_pix_ok    = w_scan && pix_req;
        w_in_row    = (r_pix_cnt != CNT_W'(PIX_PER_ROW));
        w_consume   = w_pix_ok && w_in_row;
        w_shift     = w_consume && (r_bit == BIT_W'(WORD_W - 1));
        w_frame_end = w_consume && (r_row == ROW_W'(ROWS - 1)) &&
                      (r_pix_cnt == CNT_W'(PIX_PER_ROW - 1));
        w_ls        = w_scan && line_start;
        w_short     = w_ls && (r_pix_cnt != '0) && w_in_row;
        w_capture   = r_rd_pipe[RD_LATENCY-1];
        w_accept    = w_scan && r_req_pend && !wait_request;
        w_issue     = w_scan && !w_short && !w_frame_end && (!r_front_vld || !r_back_vld) &&
                      !r_req_pend && (r_rd_pipe == '0) && !r_fetch_ptr[ADDR_W];
        w_next_row  = {1'b0, r_row} + {{ROW_W{1'b0}}, !r_first_line};
        w_row_ptr   = {w_next_row, {WPR_W{1'b0}}};
        w_pipe_nxt  = {r_rd_pipe, w_accept};
    end

    always_comb begin
        w_next_state = r_state;
        if (frame_start)
            w_next_state = SCAN;
        else if (w_frame_end)
            w_next_state = DONE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_state <= IDLE;
        else
            r_state <= w_next_state;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_front       <= '0;
            r_back        <= '0;
            r_front_vld   <= 1'b0;
            r_back_vld    <= 1'b0;
            r_fetch_ptr   <= '0;
            r_addr        <= '0;
            r_req_pend    <= 1'b0;
            r_rd_pipe     <= '0;
            r_bit         <= '0;
            r_pix_cnt     <= '0;
            r_row         <= '0;
            r_first_line  <= 1'b1;
            r_ready       <= 1'b0;
            r_pixel       <= 1'b0;
            r_pixel_valid <= 1'b0;
            r_underflow   <= 1'b0;
        end else if (frame_start) begin
            // Clearing the return pipeline drops any read still in flight.
            r_front_vld   <= 1'b0;
            r_back_vld    <= 1'b0;
            r_fetch_ptr   <= '0;
            r_req_pend    <= 1'b0;
            r_rd_pipe     <= '0;
            r_bit         <= '0;
            r_pix_cnt     <= '0;
            r_row         <= '0;
            r_first_line  <= !line_start;
            r_ready       <= 1'b0;
            r_pixel_valid <= 1'b0;
        end else begin
            r_pixel_valid <= w_pix_ok;
            if (w_pix_ok) begin
                if (!w_in_row || !r_front_vld) begin
                    r_pixel     <= 1'b0;
                    r_underflow <= 1'b1;
                end else begin
                    r_pixel <= r_front[r_bit];
                end
            end
            if (w_frame_end) begin
                r_ready    <= 1'b1;
                r_req_pend <= 1'b0;
            end
            if (w_short) begin
                r_front_vld  <= 1'b0;
                r_back_vld   <= 1'b0;
                r_req_pend   <= 1'b0;
                r_rd_pipe    <= '0;
                r_fetch_ptr  <= w_row_ptr;
                r_row        <= w_next_row[ROW_W-1:0];
                r_bit        <= '0;
                r_pix_cnt    <= '0;
                r_first_line <= 1'b0;
            end else begin
                if (w_ls) begin
                    r_pix_cnt    <= '0;
                    r_row        <= w_next_row[ROW_W-1:0];
                    r_first_line <= 1'b0;
                end else if (w_consume) begin
                    r_pix_cnt <= r_pix_cnt + CNT_W'(1);
                end
                if (w_consume)
                    r_bit <= w_shift ? '0 : r_bit + BIT_W'(1);
                r_rd_pipe <= w_pipe_nxt[RD_LATENCY-1:0];
                if (w_issue) begin
                    r_addr     <= r_fetch_ptr[ADDR_W-1:0];
                    r_req_pend <= 1'b1;
                end
                if (w_accept) begin
                    r_req_pend  <= 1'b0;
                    r_fetch_ptr <= r_fetch_ptr + {{ADDR_W{1'b0}}, 1'b1};
                end
                // A word returning on the same cycle the front drains goes wherever the shift leaves a hole.
                if (w_shift) begin
                    if (r_back_vld) begin
                        r_front     <= r_back;
                        r_front_vld <= 1'b1;
                        r_back_vld  <= w_capture;
                        if (w_capture)
                            r_back <= q_b;
                    end else begin
                        r_front_vld <= w_capture;
                        r_back_vld  <= 1'b0;
                        if (w_capture)
                            r_front <= q_b;
                    end
                end else if (w_capture) begin
                    if (!r_front_vld) begin
                        r_front     <= q_b;
                        r_front_vld <= 1'b1;
                    end else begin
                        r_back     <= q_b;
                        r_back_vld <= 1'b1;
                    end
                end
            end
        end
    end

    assign address_b   = r_addr;
    assign ready_sig   = r_ready;
    assign pixel       = r_pixel;
    assign pixel_valid = r_pixel_valid;
    assign underflow   = r_underflow;
endmodule

// File: tb/tb_conway_scan_reader.sv
// Directed bench for conway_scan_reader on a reduced 8-row grid (64 words x 20 cells per row).
module tb_conway_scan_reader;
    localparam int WORD_W = 20;
    localparam int WPR    = 64;
    localparam int ROWS   = 8;
    localparam int ADDR_W = 9;
    localparam int PPR    = WORD_W * WPR;

    logic              clk = 1'b0;
    logic              reset, frame_start, line_start, pix_req, wait_request;
    logic [ADDR_W-1:0] address_b;
    logic [WORD_W-1:0] q_b;
    logic              ready_sig, pixel, pixel_valid, underflow;

    int n_tests = 0;
    int n_fail  = 0;

    conway_scan_reader #(
        .WORD_W(WORD_W), .WORDS_PER_ROW(WPR), .ROWS(ROWS), .ADDR_W(ADDR_W), .RD_LATENCY(1)
    ) dut (
        .clk(clk), .reset(reset), .frame_start(frame_start), .line_start(line_start),
        .pix_req(pix_req), .address_b(address_b), .q_b(q_b), .wait_request(wait_request),
        .ready_sig(ready_sig), .pixel(pixel), .pixel_valid(pixel_valid), .underflow(underflow)
    );

    always #5 clk = ~clk;

    // Memory word k holds k[19:0]; read data follows the address by one cycle.
    always @(posedge clk) q_b <= WORD_W'(address_b);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: event not seen within cycle budget", name);
    endtask

    function automatic logic model_px(input int word, input int b);
        return logic'((word >> b) & 1);
    endfunction

    logic              mon_en = 1'b0;
    logic [ADDR_W-1:0] mon_prev;
    always @(negedge clk) begin
        if (mon_en && address_b !== mon_prev) begin
            chk("addr_seq", 32'(address_b), 32'(mon_prev) + 1);
            mon_prev = address_b;
        end
    end

    int hold_addr = -1;
    int hold_left = 0;
    bit held      = 1'b0;

    task automatic cyc();
        @(posedge clk);
        #1;
        if (hold_left > 0) begin
            chk("hold_addr", 32'(address_b), 32'(hold_addr));
            hold_left--;
            if (hold_left == 0)
                wait_request = 1'b0;
        end else if (hold_addr >= 0 && !held && int'(address_b) == hold_addr) begin
            held         = 1'b1;
            hold_left    = 6;
            wait_request = 1'b1;
        end
    endtask

    task automatic pix_stream(input int row, input int first, input int count, input int gap);
        for (int n = first; n < first + count; n++) begin
            pix_req = 1'b1;
            cyc();
            pix_req = 1'b0;
            chk($sformatf("pix r%0d n%0d", row, n), {30'd0, pixel_valid, pixel},
                {30'd0, 1'b1, model_px(row * WPR + n / WORD_W, n % WORD_W)});
            for (int g = 1; g < gap; g++)
                cyc();
        end
    endtask

    task automatic run_row(input int row, input int npix, input int gap, input int exp_first);
        logic [ADDR_W-1:0] prev;
        bit seen;
        line_start = 1'b1;
        cyc();
        line_start = 1'b0;
        prev = address_b;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            cyc();
            if (exp_first >= 0 && !seen && address_b !== prev) begin
                seen = 1'b1;
                chk("first_fetch", 32'(address_b), 32'(exp_first));
            end
        end
        if (exp_first >= 0 && !seen)
            fail("first_fetch");
        pix_stream(row, 0, npix, gap);
    endtask

    typedef struct {
        logic fs, ls, pr;
        logic exp_pv, exp_px, exp_rdy, exp_uf;
    } vec_t;
    vec_t tbl[59];

    initial begin
        logic [ADDR_W-1:0] last_addr, prev;
        bit found;
        int n;

        for (int i = 0; i < 59; i++)
            tbl[i] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[1].fs  = 1'b1;
        tbl[10].ls = 1'b1;
        // Words 0 and 1: only cell 0 of word 1 (pixel 20) is alive.
        for (int i = 19; i < 59; i++) begin
            tbl[i].pr     = 1'b1;
            tbl[i].exp_pv = 1'b1;
            tbl[i].exp_px = (i - 19 == 20);
        end

        reset = 1'b1; frame_start = 1'b0; line_start = 1'b0; pix_req = 1'b0; wait_request = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_state", {19'd0, address_b, ready_sig, pixel, pixel_valid, underflow}, 32'd0);
        reset = 1'b0;

        // Row 0 streamed back to back; fetch addresses must climb by one.
        mon_prev = '0;
        mon_en   = 1'b1;
        for (int i = 0; i < 59; i++) begin
            frame_start = tbl[i].fs;
            line_start  = tbl[i].ls;
            pix_req     = tbl[i].pr;
            cyc();
            chk($sformatf("vec%0d", i), {28'd0, pixel_valid, pixel, ready_sig, underflow},
                {28'd0, tbl[i].exp_pv, tbl[i].exp_px, tbl[i].exp_rdy, tbl[i].exp_uf});
        end
        frame_start = 1'b0; line_start = 1'b0; pix_req = 1'b0;
        pix_stream(0, 40, PPR - 40, 1);
        mon_en = 1'b0;
        chk("row0_uf", 32'(underflow), 32'd0);
        chk("row0_addr_reach", 32'(mon_prev >= 63), 32'd1);

        // Wait-state on address 5 with slow pixel rate.
        frame_start = 1'b1;
        cyc();
        frame_start = 1'b0;
        hold_addr = 5;
        run_row(0, 200, 4, -1);
        chk("hold_seen", 32'(held), 32'd1);
        chk("hold_uf", 32'(underflow), 32'd0);
        hold_addr = -1;

        // Starvation: memory stalls for 40 cycles while pixels are requested.
        frame_start = 1'b1;
        cyc();
        frame_start = 1'b0;
        for (int i = 0; i < 40; i++) begin
            wait_request = 1'b1;
            pix_req      = 1'b1;
            cyc();
            chk($sformatf("starve%0d", i), {30'd0, pixel_valid, pixel}, 32'd2);
        end
        wait_request = 1'b0; pix_req = 1'b0;
        repeat (3) cyc();
        chk("uf_set", 32'(underflow), 32'd1);
        frame_start = 1'b1;
        cyc();
        frame_start = 1'b0;
        chk("uf_sticky", 32'(underflow), 32'd1);
        line_start = 1'b1;
        cyc();
        line_start = 1'b0;
        repeat (5) cyc();
        pix_req = 1'b1;
        repeat (10) cyc();
        @(posedge clk);
        #2 reset = 1'b1;
        #1 chk("rst_async", {19'd0, address_b, ready_sig, pixel, pixel_valid, underflow}, 32'd0);
        pix_req = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Full frame with a short row 3.
        frame_start = 1'b1;
        cyc();
        frame_start = 1'b0;
        for (int r = 0; r < ROWS - 1; r++)
            run_row(r, (r == 3) ? 700 : PPR, 1, (r == 4) ? 256 : -1);
        run_row(ROWS - 1, PPR - 1, 1, -1);
        chk("ready_low", 32'(ready_sig), 32'd0);
        pix_stream(ROWS - 1, PPR - 1, 1, 1);
        chk("ready_rise", 32'(ready_sig), 32'd1);
        last_addr = address_b;
        repeat (20) cyc();
        chk("done_hold", {22'd0, ready_sig, address_b}, {22'd0, 1'b1, last_addr});
        chk("done_uf", 32'(underflow), 32'd0);
        frame_start = 1'b1;
        cyc();
        frame_start = 1'b0;
        chk("ready_fall", 32'(ready_sig), 32'd0);

        // Abort mid-row 5 while a read is in flight.
        for (int r = 0; r < 5; r++)
            run_row(r, PPR, 1, -1);
        run_row(5, 100, 1, -1);
        prev  = address_b;
        found = 1'b0;
        n     = 100;
        while (n < PPR - 1 && !found) begin
            pix_stream(5, n, 1, 1);
            n++;
            if (address_b !== prev)
                found = 1'b1;
        end
        if (!found)
            fail("abort_req");
        pix_stream(5, n, 1, 1);
        frame_start = 1'b1;
        pix_req     = 1'b1;
        cyc();
        frame_start = 1'b0;
        pix_req     = 1'b0;
        chk("fs_prio", {30'd0, pixel_valid, ready_sig}, 32'd0);
        found = 1'b0;
        for (int i = 0; i < 8 && !found; i++) begin
            cyc();
            if (address_b == '0)
                found = 1'b1;
        end
        if (!found)
            fail("restart_addr0");
        run_row(0, 60, 1, -1);
        chk("abort_uf", 32'(underflow), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/conway_scan_reader.md
Name: conway_scan_reader

Overview:
- Display-side reader for the Conway accelerator's frame memory port B.
- Walks the current generation grid in raster order: 1024 rows x 64 words x 20 cells, i.e. 1280x1024 pixels.
- Issues word addresses, captures the read data, and serializes one cell per pixel strobe to the VGA pixel pipeline.
- Drives ready_sig back to the accelerator so the generation buffers swap only while no frame is being scanned.

Parameters:
- WORD_W, 20, cells per memory word.
- WORDS_PER_ROW, 64, words per grid row.
- ROWS, 1024, grid rows per frame.
- ADDR_W, 16, word address width; must satisfy 2^ADDR_W = WORDS_PER_ROW*ROWS.
- RD_LATENCY, 1, cycles from an accepted address to valid q_b.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- frame_start  in  1  one-cycle pulse from the timing generator before row 0.
- line_start  in  1  one-cycle pulse before each visible row.
- pix_req  in  1  one-cycle pulse per visible pixel.
- address_b  out  ADDR_W  word address to the accelerator port B.
- q_b  in  WORD_W  read data from the accelerator.
- wait_request  in  1  high means address_b is not accepted this cycle.
- ready_sig  out  1  high means the scan is finished and the accelerator may swap buffers.
- pixel  out  1  cell value (1 = alive).
- pixel_valid  out  1  pixel qualifier.
- underflow  out  1  sticky error flag.

Behaviour:
- One clock domain; reset is asynchronous and active-high, ports named clk and reset.
- Reset values: address_b=0, ready_sig=0, pixel=0, pixel_valid=0, underflow=0. State=IDLE, all buffers invalid, fetch pointer=0, bit index=0, row=0.
- States:
  - IDLE: no fetches issued.
  - SCAN: active frame.
  - DONE: frame finished.
- IDLE/DONE -> SCAN on frame_start. Actions on that transition:
  - flush front and back word buffers;
  - fetch pointer=0, row=0, bit index=0;
  - ready_sig=0 from the next cycle.
- frame_start while in SCAN aborts the current frame and restarts identically. Any read still outstanding is discarded by tag; a late q_b must not land in a buffer.
- Buffers:
  - Front word register: pixel source.
  - Back word register: prefetch.
  - Each has a valid bit.
  - At most one read outstanding.
- Fetch rule: in SCAN, if a buffer slot is free, no read is outstanding and the fetch pointer < 65536, drive address_b=fetch pointer.
  - An address is accepted on a cycle with wait_request=0.
  - While wait_request=1, address_b is held stable.
  - q_b is captured exactly RD_LATENCY cycles after acceptance.
  - It fills the front buffer if front is invalid, else the back buffer.
  - Pointer increments by 1 on acceptance and never wraps past 65535.
- Serialization:
  - On pix_req, pixel <= front[bit index] and pixel_valid=1 on the next cycle. pixel_valid is 0 otherwise.
  - Bit 0 is the leftmost cell of the word.
  - Bit index increments mod WORD_W.
  - On the pix_req that consumes bit WORD_W-1, front <= back (with its valid bit) and back is marked invalid, in the same cycle.
- Underflow: a pix_req when front is invalid has these effects:
  - pixel=0 and pixel_valid=1;
  - underflow set; it clears only on reset;
  - bit index still advances.
- Row accounting:
  - A per-row pixel counter runs 0..1279.
  - On line_start with counter = 0 or 1280: no action other than counter=0, row++ (the first line_start of a frame does not increment row).
  - On line_start with any other counter value (short/long line): flush both buffers and drop any outstanding read, then set fetch pointer=row*WORDS_PER_ROW for the new row, bit index=0, counter=0.
  - pix_req beyond 1280 in a row: pixel=0, pixel_valid=1, set underflow.
- Frame end:
  - The 1280th pix_req of row ROWS-1 moves SCAN -> DONE.
  - ready_sig=1 from the following cycle until the cycle after the next frame_start.
  - In DONE, address_b holds its last value and no fetch is issued.
- Simultaneous events: frame_start has priority over line_start and pix_req in the same cycle. The pix_req is ignored and line_start is treated as already done for row 0.
- Throughput: the buffers sustain one pix_req per cycle provided wait_request is low at least 1 of every 10 cycles and RD_LATENCY ≤ 4.

Test Plan:
- Reset, then frame_start. Memory word k = k[19:0]. 1280 back-to-back pix_req -> addresses 0..63 issued in order; pixel stream equals bits of words 0..63 LSB-first; underflow=0.
- wait_request held high 6 cycles on address 5 while pix_req runs at 1 per 4 cycles -> address_b stable at 5 throughout; no underflow; stream unchanged.
- frame_start then pix_req every cycle with wait_request high 40 cycles -> pixel=0 for starved requests; underflow=1 and stays 1 until reset.
- Row 3 given only 700 pix_req then line_start -> the next fetch address is 256; the first pixel of row 4 is bit 0 of word 256.
- Full frame of 1024x1280 pix_req -> ready_sig rises one cycle after the last pix_req, stays high through idle cycles, and falls one cycle after frame_start; address_b stays constant during DONE.
- frame_start asserted mid-row 500 with a read outstanding, and reset asserted mid-row on a second run -> first: restart at address 0 with the stale q_b discarded; second: all outputs at reset values in the same cycle.
